// File: rtl/opb_register_bank.sv
// OPB slave exposing C_NUM_REGS software registers with byte-enable writes, readback,
// per-register write strobes and an optional shadow/commit double-buffered mode.
module opb_register_bank #(
  parameter logic [31:0] C_BASEADDR   = 32'h010B2000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010B20FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned C_NUM_REGS   = 8,
  parameter int unsigned C_DOUBLE_BUF = 1,
  parameter logic [31:0] C_RESET_VAL  = 32'h0
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]    user_data_out,
  output logic [C_NUM_REGS-1:0]       user_wr_strb,
  output logic                        user_commit_strb
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_GAP} state_e;

  localparam logic [5:0] CTRL_IDX = 6'h20;

  state_e                state_q;
  logic                  ack_q;
  logic [31:0]           dbus_q;

  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic [31:0]           bmask;
  logic [5:0]            idx;
  logic                  hit;
  logic                  access;
  logic                  is_ctrl;
  logic                  unused_seq;

  logic [31:0]           shadow_q [C_NUM_REGS];
  logic [31:0]           shadow_d [C_NUM_REGS];
  logic [31:0]           active_q [C_NUM_REGS];
  logic [31:0]           active_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] pending_q, pending_d;
  logic [C_NUM_REGS-1:0] wr_strb_q, wr_strb_d;
  logic                  commit_q, commit_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           pend16;
  logic [31:0]           rdata;

  // Big-endian OPB vectors map straight onto little-endian user bit numbering.
  assign addr       = OPB_ABus;
  assign wdata      = OPB_DBus;
  assign be         = OPB_BE;
  assign unused_seq = OPB_seqAddr;

  assign idx     = addr[7:2];
  assign hit     = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign access  = hit && (state_q == S_IDLE);
  assign is_ctrl = (idx == CTRL_IDX);

  always_comb begin
    bmask = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      bmask[8*b +: 8] = {8{be[b]}};
    end
  end

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    wr_strb_d = '0;
    commit_d  = 1'b0;
    rdata     = '0;
    pend16    = '0;
    pend16[C_NUM_REGS-1:0] = pending_q;

    for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
      if (idx == 6'(i)) begin
        rdata = (C_DOUBLE_BUF != 0) ? shadow_q[i] : active_q[i];
      end
    end
    if (is_ctrl) begin
      rdata = {cnt_q, pend16};
    end

    if (access && !OPB_RNW) begin
      for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
        if (idx == 6'(i)) begin
          wr_strb_d[i] = 1'b1;
          if (C_DOUBLE_BUF != 0) begin
            shadow_d[i]  = (shadow_q[i] & ~bmask) | (wdata & bmask);
            pending_d[i] = 1'b1;
          end else begin
            active_d[i]  = (active_q[i] & ~bmask) | (wdata & bmask);
          end
        end
      end
      if (is_ctrl && (C_DOUBLE_BUF != 0) && be[0] && wdata[0]) begin
        active_d  = shadow_q;
        pending_d = '0;
        cnt_d     = cnt_q + 16'd1;
        commit_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      shadow_q  <= '{default: C_RESET_VAL};
      active_q  <= '{default: C_RESET_VAL};
      pending_q <= '0;
      wr_strb_q <= '0;
      commit_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      wr_strb_q <= wr_strb_d;
      commit_q  <= commit_d;
      cnt_q     <= cnt_d;
    end
  end

  // Read data is captured when the access is performed and shown only while acking.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      dbus_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q  <= 1'b0;
          dbus_q <= '0;
          if (hit) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            if (OPB_RNW) begin
              dbus_q <= rdata;
            end
          end
        end
        S_ACK: begin
          state_q <= S_GAP;
          ack_q   <= 1'b0;
          dbus_q  <= '0;
        end
        S_GAP: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          dbus_q  <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          dbus_q  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    user_data_out = '0;
    for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
      user_data_out[32*i +: 32] = active_q[i];
    end
  end

  assign Sl_DBus          = dbus_q;
  assign Sl_xferAck       = ack_q;
  assign Sl_errAck        = 1'b0;
  assign Sl_retry         = 1'b0;
  assign Sl_toutSup       = 1'b0;
  assign user_wr_strb     = wr_strb_q;
  assign user_commit_strb = commit_q;

endmodule

// File: tb/tb_opb_register_bank.sv
// Bench for opb_register_bank: double-buffered and direct-write instances on a shared bus,
// checked against directed vectors and a behavioural register-bank model.
module tb_opb_register_bank;

  localparam logic [31:0] BASE = 32'h010B2000;
  localparam logic [31:0] HIGH = 32'h010B20FF;
  localparam logic [31:0] CTRL = 32'h010B2080;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:31]   abus;
  logic [0:3]    be;
  logic [0:31]   dbus;
  logic          rnw, sel, seq;

  logic [0:31]   sdbus1, sdbus0;
  logic          ack1, ack0, err1, err0, rty1, rty0, tout1, tout0;
  logic [255:0]  udo1, udo0;
  logic [7:0]    ws1, ws0;
  logic          cs1, cs0;

  int checks = 0;
  int errors = 0;

  logic [31:0]   m_shadow  [8];
  logic [31:0]   m_active  [8];
  logic [31:0]   m_active0 [8];
  logic [7:0]    m_pend;
  int unsigned   m_cnt;

  always #5 clk = ~clk;

  opb_register_bank #(.C_DOUBLE_BUF(1)) dut1 (
    .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sdbus1), .Sl_xferAck(ack1), .Sl_errAck(err1), .Sl_retry(rty1), .Sl_toutSup(tout1),
    .user_data_out(udo1), .user_wr_strb(ws1), .user_commit_strb(cs1));

  opb_register_bank #(.C_DOUBLE_BUF(0)) dut0 (
    .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sdbus0), .Sl_xferAck(ack0), .Sl_errAck(err0), .Sl_retry(rty0), .Sl_toutSup(tout0),
    .user_data_out(udo0), .user_wr_strb(ws0), .user_commit_strb(cs0));

  typedef struct {
    logic [31:0] a;
    bit          rnw;
    logic [3:0]  be;
    logic [31:0] d;
    bit          eack;
    logic [31:0] erd;
    logic [7:0]  ews;
    bit          ecs;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] bev);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (bev[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = '0; m_active[i] = '0; m_active0[i] = '0;
    end
    m_pend = '0;
    m_cnt  = 0;
  endtask

  task automatic chk_user();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("active1[%0d]", i), udo1[32*i +: 32], m_active[i]);
      chk($sformatf("active0[%0d]", i), udo0[32*i +: 32], m_active0[i]);
    end
  endtask

  task automatic idle_bus();
    sel = 1'b0; rnw = 1'b1; be = 4'h0; dbus = '0; abus = '0;
  endtask

  // One transfer on both instances; the model is consulted before the access lands.
  task automatic bus(input logic [31:0] a, input bit r, input logic [3:0] bev, input logic [31:0] d,
                     output bit ack_o, output logic [31:0] rd_o, output logic [7:0] ws_o,
                     output bit cs_o);
    bit inap, isreg, isctrl, commit;
    int unsigned idx;
    logic [31:0] e1, e0, rd0v;
    logic [7:0]  ews;
    inap   = (a >= BASE) && (a <= HIGH);
    idx    = (a >> 2) % 64;
    isreg  = inap && (idx < 8);
    isctrl = inap && (idx == 32);
    e1 = '0; e0 = '0; ews = '0;
    if (r && isreg) begin
      e1 = m_shadow[idx[2:0]];
      e0 = m_active0[idx[2:0]];
    end
    if (r && isctrl) e1 = {m_cnt[15:0], 8'h00, m_pend};
    if (!r && isreg) ews = 8'(32'd1 << idx);
    commit = !r && isctrl && bev[0] && d[0];
    if (!r && isreg) begin
      m_shadow[idx[2:0]]  = merge(m_shadow[idx[2:0]], d, bev);
      m_active0[idx[2:0]] = merge(m_active0[idx[2:0]], d, bev);
      m_pend[idx[2:0]]    = 1'b1;
    end
    if (commit) begin
      for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
      m_pend = '0;
      m_cnt  = (m_cnt + 1) % 65536;
    end

    abus = a; rnw = r; be = bev; dbus = d; sel = 1'b1;
    @(posedge clk); #1;
    ack_o = ack1; rd_o = sdbus1; ws_o = ws1; cs_o = cs1; rd0v = sdbus0;
    chk("ack1", 32'(ack1), 32'(inap));
    chk("ack0", 32'(ack0), 32'(inap));
    chk("rdata1", rd_o, e1);
    chk("rdata0", rd0v, e0);
    chk("wr_strb1", 32'(ws1), 32'(ews));
    chk("wr_strb0", 32'(ws0), 32'(ews));
    chk("commit1", 32'(cs1), 32'(commit));
    chk("commit0", 32'(cs0), 32'd0);
    chk("tied0", 32'({err1, rty1, tout1, err0, rty0, tout0}), 32'd0);
    chk_user();
    idle_bus();
    @(posedge clk); #1;
    chk("gap_ack", 32'({ack1, ack0}), 32'd0);
    chk("gap_dbus", 32'(sdbus1) | 32'(sdbus0), 32'd0);
    chk("gap_strb", 32'({ws1, ws0, cs1, cs0}), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ack; logic [31:0] rd; logic [7:0] ws; bit cs;
    int n_ack, n_cs;
    logic [31:0] dbor;
    bit exp_pat [6];

    seq = 1'b0;
    idle_bus();
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'({ack1, ack0}), 32'd0);
    chk("rst_dbus", 32'(sdbus1) | 32'(sdbus0), 32'd0);
    chk("rst_udo", 32'(|{udo1, udo0}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_dbus", 32'(sdbus1), 32'd0);

    //            addr           rnw be     data           ack  rdata          strb   commit
    vt.push_back('{BASE,         1, 4'hF, 32'h0,         1, 32'h0,         8'h00, 0});
    vt.push_back('{CTRL,         1, 4'hF, 32'h0,         1, 32'h0,         8'h00, 0});
    vt.push_back('{32'h010B2004, 0, 4'hF, 32'hDEADBEEF,  1, 32'h0,         8'h02, 0});
    vt.push_back('{CTRL,         1, 4'hF, 32'h0,         1, 32'h00000002,  8'h00, 0});
    vt.push_back('{32'h010B2004, 1, 4'h0, 32'h0,         1, 32'hDEADBEEF,  8'h00, 0});
    vt.push_back('{CTRL,         0, 4'hF, 32'h1,         1, 32'h0,         8'h00, 1});
    vt.push_back('{CTRL,         1, 4'hF, 32'h0,         1, 32'h00010000,  8'h00, 0});
    vt.push_back('{32'h010B2004, 0, 4'h5, 32'h11223344,  1, 32'h0,         8'h02, 0});
    vt.push_back('{CTRL,         1, 4'hF, 32'h0,         1, 32'h00010002,  8'h00, 0});
    vt.push_back('{CTRL,         0, 4'hF, 32'h1,         1, 32'h0,         8'h00, 1});
    vt.push_back('{32'h010B2004, 1, 4'hF, 32'h0,         1, 32'hDE22BE44,  8'h00, 0});
    vt.push_back('{32'h010B2040, 1, 4'hF, 32'h0,         1, 32'h0,         8'h00, 0});
    vt.push_back('{32'h010B2040, 0, 4'hF, 32'hFFFFFFFF,  1, 32'h0,         8'h00, 0});
    vt.push_back('{32'h010B2020, 1, 4'hF, 32'h0,         1, 32'h0,         8'h00, 0});
    vt.push_back('{CTRL,         0, 4'hE, 32'h1,         1, 32'h0,         8'h00, 0});
    vt.push_back('{CTRL,         0, 4'hF, 32'h0,         1, 32'h0,         8'h00, 0});
    vt.push_back('{CTRL,         1, 4'hF, 32'h0,         1, 32'h00020000,  8'h00, 0});
    vt.push_back('{32'h010B2008, 0, 4'hF, 32'hA5A55A5A,  1, 32'h0,         8'h04, 0});
    vt.push_back('{32'h010B20FF, 1, 4'hF, 32'h0,         1, 32'h0,         8'h00, 0});
    vt.push_back('{32'h010B2100, 1, 4'hF, 32'h0,         0, 32'h0,         8'h00, 0});
    vt.push_back('{32'h010B1FFF, 1, 4'hF, 32'h0,         0, 32'h0,         8'h00, 0});
    vt.push_back('{32'h010B201C, 0, 4'h8, 32'hCAFEF00D,  1, 32'h0,         8'h80, 0});
    vt.push_back('{32'h010B201C, 1, 4'hF, 32'h0,         1, 32'hCA000000,  8'h00, 0});
    vt.push_back('{CTRL,         1, 4'hF, 32'h0,         1, 32'h00020084,  8'h00, 0});

    for (int k = 0; k < vt.size(); k++) begin
      bus(vt[k].a, vt[k].rnw, vt[k].be, vt[k].d, ack, rd, ws, cs);
      chk($sformatf("vec%0d_ack", k), 32'(ack), 32'(vt[k].eack));
      chk($sformatf("vec%0d_rdata", k), rd, vt[k].erd);
      chk($sformatf("vec%0d_strb", k), 32'(ws), 32'(vt[k].ews));
      chk($sformatf("vec%0d_commit", k), 32'(cs), 32'(vt[k].ecs));
    end

    // Held select on a hit: re-accepted every third cycle.
    exp_pat = '{1, 0, 0, 1, 0, 0};
    abus = BASE + 32'h4; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ack%0d", c), 32'(ack1), 32'(exp_pat[c]));
      chk($sformatf("b2b_dbus%0d", c), 32'(sdbus1), exp_pat[c] ? m_shadow[1] : 32'h0);
    end
    idle_bus();
    @(posedge clk); #1;

    // Miss held for 16 cycles is never acknowledged.
    abus = 32'h010B3000; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    n_ack = 0; dbor = '0;
    repeat (16) begin
      @(posedge clk); #1;
      n_ack += int'(ack1) + int'(ack0);
      dbor |= 32'(sdbus1) | 32'(sdbus0);
    end
    chk("miss16_acks", 32'(n_ack), 32'd0);
    chk("miss16_dbus", dbor, 32'd0);
    idle_bus();
    @(posedge clk); #1;

    // Commit burst with select held: one commit per three cycles, counter passes 8 bits.
    abus = CTRL; rnw = 1'b0; be = 4'hF; dbus = 32'h1; sel = 1'b1;
    n_cs = 0;
    repeat (3 * 700) begin
      @(posedge clk); #1;
      n_cs += int'(cs1);
    end
    idle_bus();
    chk("burst_commits", 32'(n_cs), 32'd700);
    for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
    m_pend = '0;
    m_cnt  = (m_cnt + 700) % 65536;
    chk_user();
    bus(CTRL, 1, 4'hF, 32'h0, ack, rd, ws, cs);
    chk("burst_ctrl", rd, {16'(m_cnt), 16'h0000});

    // Reset asserted inside the ack cycle.
    abus = 32'h010B200C; rnw = 1'b0; be = 4'hF; dbus = 32'h12345678; sel = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_pre_ack", 32'(ack1), 32'd1);
    rst_n = 1'b0;
    idle_bus();
    #1;
    chk("rst_mid_ack", 32'({ack1, ack0}), 32'd0);
    chk("rst_mid_dbus", 32'(sdbus1) | 32'(sdbus0), 32'd0);
    chk("rst_mid_udo", 32'(|{udo1, udo0}), 32'd0);
    chk("rst_mid_strb", 32'({ws1, ws0, cs1, cs0}), 32'd0);
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus(CTRL, 1, 4'hF, 32'h0, ack, rd, ws, cs);
    chk("rst_mid_ctrl", rd, 32'h0);

    // Randomised traffic against the model.
    for (int t = 0; t < 400; t++) begin
      logic [31:0] a, d;
      bit r;
      logic [3:0] bv;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = BASE + 32'(4 * $urandom_range(0, 7));
        5:             a = BASE + 32'(4 * $urandom_range(8, 31)) + 32'($urandom_range(0, 3));
        6, 7:          a = CTRL;
        8:             a = BASE + 32'(4 * $urandom_range(33, 63)) + 32'($urandom_range(0, 3));
        default: begin
          case ($urandom_range(0, 3))
            0:       a = BASE - 32'd1;
            1:       a = HIGH + 32'd1;
            2:       a = 32'h010B3000;
            default: a = $urandom;
          endcase
        end
      endcase
      r  = 1'($urandom_range(0, 1));
      bv = 4'($urandom);
      d  = $urandom;
      bus(a, r, bv, d, ack, rd, ws, cs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
